// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//
// Sequences the shared multiply and divide units and the HI/LO registers for
// the multicycle CPU. Takes one request at a time from the main control FSM,
// pulses the selected unit's start, waits for its end flag, then steers the
// HI/LO muxes and pulses the HI/LO write enable. It raises a divide-by-zero
// exception instead of writing when the divider reports a zero divisor.
//
// Optional feature: define MULDIV_TIMEOUT_EN to add a RUN-state watchdog.
// If neither an end flag nor a divide-by-zero arrives within TIMEOUT_CYCLES
// RUN cycles, the operation is abandoned without a write and o_timeout_exc
// pulses. Without the macro there is no counter, the RUN states wait
// indefinitely, and o_timeout_exc is constant 0.
//
// Parameters
//   TIMEOUT_CYCLES  RUN-state cycle limit (watchdog build only)
//   CNT_W           run counter width, 2**CNT_W > TIMEOUT_CYCLES
//
// Ports
//   i_clk          clock, all state on the rising edge
//   i_rst          synchronous reset, active low
//   i_req_mult     start MULT request, sampled only in IDLE
//   i_req_div      start DIV request, sampled only in IDLE (wins over mult)
//   i_mult_end     multiply unit finished
//   i_div_end      divide unit finished
//   i_div_by_zero  divide unit reports a zero divisor
//   o_mult_start   1-cycle start pulse to the multiply unit
//   o_div_start    1-cycle start pulse to the divide unit
//   o_hi_sel       HICtrl mux select, 0 = mult, 1 = div
//   o_lo_sel       LOCtrl mux select, 0 = mult, 1 = div
//   o_hilo_we      HI/LO write enable, 1 cycle
//   o_busy         high whenever the sequencer is not idle
//   o_done         completion pulse, coincident with o_hilo_we
//   o_div_zero_exc divide-by-zero exception pulse
//   o_timeout_exc  watchdog timeout exception pulse
//
// State table
//   S_IDLE     | waiting for a request
//   S_MULT_RUN | multiply unit running, start pulsed in first cycle
//   S_DIV_RUN  | divide unit running, start pulsed in first cycle
//   S_WRITE    | write HI/LO and signal done, one cycle
//   S_DZ       | divide-by-zero exception, one cycle, no write
//   S_TIMEOUT  | watchdog expired, one cycle, no write (watchdog build only)
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req_mult,
    input  logic i_req_div,
    input  logic i_mult_end,
    input  logic i_div_end,
    input  logic i_div_by_zero,
    output logic o_mult_start,
    output logic o_div_start,
    output logic o_hi_sel,
    output logic o_lo_sel,
    output logic o_hilo_we,
    output logic o_busy,
    output logic o_done,
    output logic o_div_zero_exc,
    output logic o_timeout_exc
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MULT_RUN = 3'd1,
        S_DIV_RUN  = 3'd2,
        S_WRITE    = 3'd3,
        S_DZ       = 3'd4,
        S_TIMEOUT  = 3'd5
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_first;   // previous cycle was IDLE, so this is the first RUN cycle
    logic   r_sel;     // HI/LO source of the most recent write
    logic   w_timeout;

    // The run counter must be able to reach TIMEOUT_CYCLES-1.
    if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_cfg_check
        $error("muldiv_sequencer: CNT_W too small for TIMEOUT_CYCLES");
    end

`ifdef MULDIV_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;

    // Held at zero outside RUN, so it is already clear on RUN entry.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_cnt <= '0;
        end else if (r_state == S_MULT_RUN || r_state == S_DIV_RUN) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // True in the TIMEOUT_CYCLES-th RUN cycle; end flags are checked first.
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_first <= 1'b0;
            r_sel   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_first <= (r_state == S_IDLE);
            if (w_next == S_WRITE) begin
                r_sel <= (r_state == S_DIV_RUN);
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        o_mult_start   = 1'b0;
        o_div_start    = 1'b0;
        o_hi_sel       = r_sel;
        o_lo_sel       = r_sel;
        o_hilo_we      = 1'b0;
        o_busy         = (r_state != S_IDLE);
        o_done         = 1'b0;
        o_div_zero_exc = 1'b0;
        o_timeout_exc  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_req_div) begin
                    w_next = S_DIV_RUN;
                end else if (i_req_mult) begin
                    w_next = S_MULT_RUN;
                end
            end
            S_MULT_RUN: begin
                o_mult_start = r_first;
                if (i_mult_end) begin
                    w_next = S_WRITE;
                end else if (w_timeout) begin
                    w_next = S_TIMEOUT;
                end
            end
            S_DIV_RUN: begin
                o_div_start = r_first;
                if (i_div_by_zero) begin
                    w_next = S_DZ;
                end else if (i_div_end) begin
                    w_next = S_WRITE;
                end else if (w_timeout) begin
                    w_next = S_TIMEOUT;
                end
            end
            S_WRITE: begin
                o_hilo_we = 1'b1;
                o_done    = 1'b1;
                w_next    = S_IDLE;
            end
            S_DZ: begin
                o_div_zero_exc = 1'b1;
                w_next         = S_IDLE;
            end
            S_TIMEOUT: begin
`ifdef MULDIV_TIMEOUT_EN
                o_timeout_exc = 1'b1;
`endif
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic req_mult = 1'b0, req_div = 1'b0;
    logic mult_end = 1'b0, div_end = 1'b0, div_by_zero = 1'b0;
    logic mult_start, div_start, hi_sel, lo_sel, hilo_we, busy, done;
    logic div_zero_exc, timeout_exc;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.TIMEOUT_CYCLES(8), .CNT_W(7)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_mult     (req_mult),
        .i_req_div      (req_div),
        .i_mult_end     (mult_end),
        .i_div_end      (div_end),
        .i_div_by_zero  (div_by_zero),
        .o_mult_start   (mult_start),
        .o_div_start    (div_start),
        .o_hi_sel       (hi_sel),
        .o_lo_sel       (lo_sel),
        .o_hilo_we      (hilo_we),
        .o_busy         (busy),
        .o_done         (done),
        .o_div_zero_exc (div_zero_exc),
        .o_timeout_exc  (timeout_exc)
    );

    // {mult_start, div_start, hi_sel, lo_sel, hilo_we, busy, done, dz_exc, to_exc}
    function automatic logic [8:0] ev(input logic ms, input logic ds, input logic sel,
                                      input logic we, input logic bsy, input logic dn,
                                      input logic dz, input logic to);
        return {ms, ds, sel, sel, we, bsy, dn, dz, to};
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b (ms ds hs ls we busy done dz to)", tag, obs, exp);
        end
    endtask

    // One cycle: at the falling edge drive this cycle's inputs and check the
    // outputs, which depend only on state loaded at the preceding rising edge.
    task automatic step(input logic rs, input logic rm, input logic rd, input logic me,
                        input logic de, input logic dz, input string tag,
                        input logic [8:0] exp);
        @(negedge clk);
        rst = rs; req_mult = rm; req_div = rd;
        mult_end = me; div_end = de; div_by_zero = dz;
        chk(tag, {mult_start, div_start, hi_sel, lo_sel, hilo_we, busy, done,
                  div_zero_exc, timeout_exc}, exp);
    endtask

    localparam logic [8:0] IDLE0 = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] IDLE1 = 9'b0_0_1_1_0_0_0_0_0;

    initial begin
        // reset held with a pending request
        step(0, 1, 0, 0, 0, 0, "rst_c0", IDLE0);
        step(0, 1, 0, 0, 0, 0, "rst_c1", IDLE0);
        step(1, 0, 0, 0, 0, 0, "rst_rel", IDLE0);

        // reset during MULT_RUN cycle 3 aborts
        step(1, 1, 0, 0, 0, 0, "ab_c0", IDLE0);
        step(1, 0, 0, 0, 0, 0, "ab_c1", ev(1, 0, 0, 0, 1, 0, 0, 0));
        step(1, 0, 0, 0, 0, 0, "ab_c2", ev(0, 0, 0, 0, 1, 0, 0, 0));
        step(0, 0, 0, 0, 0, 0, "ab_c3", ev(0, 0, 0, 0, 1, 0, 0, 0));
        step(1, 0, 0, 0, 0, 0, "ab_c4", IDLE0);
        step(1, 0, 0, 0, 0, 0, "ab_c5", IDLE0);

        // mult, end flag at cycle 5
        step(1, 1, 0, 0, 0, 0, "mu_c0", IDLE0);
        step(1, 0, 0, 0, 0, 0, "mu_c1", ev(1, 0, 0, 0, 1, 0, 0, 0));
        for (int c = 2; c <= 4; c++)
            step(1, 0, 0, 0, 0, 0, "mu_run", ev(0, 0, 0, 0, 1, 0, 0, 0));
        step(1, 0, 0, 1, 0, 0, "mu_c5", ev(0, 0, 0, 0, 1, 0, 0, 0));
        step(1, 0, 0, 0, 0, 0, "mu_c6", ev(0, 0, 0, 1, 1, 1, 0, 0));
        step(1, 0, 0, 0, 0, 0, "mu_c7", IDLE0);

        // div, end flag at cycle 34
        step(1, 0, 1, 0, 0, 0, "dv_c0", IDLE0);
        step(1, 0, 0, 0, 0, 0, "dv_c1", ev(0, 1, 0, 0, 1, 0, 0, 0));
        for (int c = 2; c <= 33; c++)
            step(1, 0, 0, 0, 0, 0, "dv_run", ev(0, 0, 0, 0, 1, 0, 0, 0));
        step(1, 0, 0, 0, 1, 0, "dv_c34", ev(0, 0, 0, 0, 1, 0, 0, 0));
        step(1, 0, 0, 0, 0, 0, "dv_c35", ev(0, 0, 1, 1, 1, 1, 0, 0));
        step(1, 0, 0, 0, 0, 0, "dv_c36", IDLE1);
        step(1, 0, 0, 0, 0, 0, "dv_c37", IDLE1);

        // divide by zero wins over div_end in the same cycle
        step(1, 0, 1, 0, 0, 0, "dz_c0", IDLE1);
        step(1, 0, 0, 0, 0, 0, "dz_c1", ev(0, 1, 1, 0, 1, 0, 0, 0));
        step(1, 0, 0, 0, 0, 0, "dz_c2", ev(0, 0, 1, 0, 1, 0, 0, 0));
        step(1, 0, 0, 0, 1, 1, "dz_c3", ev(0, 0, 1, 0, 1, 0, 0, 0));
        step(1, 0, 0, 0, 0, 0, "dz_c4", ev(0, 0, 1, 0, 1, 0, 1, 0));
        step(1, 0, 0, 0, 0, 0, "dz_c5", IDLE1);

        // div priority, busy request dropped
        step(1, 1, 1, 0, 0, 0, "pr_c0", IDLE1);
        step(1, 0, 0, 0, 0, 0, "pr_c1", ev(0, 1, 1, 0, 1, 0, 0, 0));
        step(1, 1, 0, 0, 0, 0, "pr_c2", ev(0, 0, 1, 0, 1, 0, 0, 0));
        step(1, 0, 0, 0, 1, 0, "pr_c3", ev(0, 0, 1, 0, 1, 0, 0, 0));
        step(1, 0, 0, 0, 0, 0, "pr_c4", ev(0, 0, 1, 1, 1, 1, 0, 0));
        step(1, 0, 0, 0, 0, 0, "pr_c5", IDLE1);
        step(1, 0, 0, 0, 0, 0, "pr_c6", IDLE1);

        // MULT_RUN ignores div flags; selects return to mult on write
        step(1, 1, 0, 0, 0, 0, "mi_c0", IDLE1);
        step(1, 0, 0, 0, 1, 1, "mi_c1", ev(1, 0, 1, 0, 1, 0, 0, 0));
        step(1, 0, 0, 1, 0, 0, "mi_c2", ev(0, 0, 1, 0, 1, 0, 0, 0));
        step(1, 0, 0, 0, 0, 0, "mi_c3", ev(0, 0, 0, 1, 1, 1, 0, 0));
        step(1, 0, 0, 0, 0, 0, "mi_c4", IDLE0);

        // mult_end in the first RUN cycle
        step(1, 1, 0, 0, 0, 0, "mf_c0", IDLE0);
        step(1, 0, 0, 1, 0, 0, "mf_c1", ev(1, 0, 0, 0, 1, 0, 0, 0));
        step(1, 0, 0, 0, 0, 0, "mf_c2", ev(0, 0, 0, 1, 1, 1, 0, 0));
        step(1, 0, 0, 0, 0, 0, "mf_c3", IDLE0);

        // DIV_RUN ignores mult_end
        step(1, 0, 1, 0, 0, 0, "di_c0", IDLE0);
        step(1, 0, 0, 1, 0, 0, "di_c1", ev(0, 1, 0, 0, 1, 0, 0, 0));
        step(1, 0, 0, 0, 1, 0, "di_c2", ev(0, 0, 0, 0, 1, 0, 0, 0));
        step(1, 0, 0, 0, 0, 0, "di_c3", ev(0, 0, 1, 1, 1, 1, 0, 0));
        step(1, 0, 0, 0, 0, 0, "di_c4", IDLE1);

`ifdef MULDIV_TIMEOUT_EN
        // no end flag: timeout after 8 RUN cycles
        step(1, 1, 0, 0, 0, 0, "to_c0", IDLE1);
        step(1, 0, 0, 0, 0, 0, "to_c1", ev(1, 0, 1, 0, 1, 0, 0, 0));
        for (int c = 2; c <= 8; c++)
            step(1, 0, 0, 0, 0, 0, "to_run", ev(0, 0, 1, 0, 1, 0, 0, 0));
        step(1, 0, 0, 0, 0, 0, "to_c9", ev(0, 0, 1, 0, 1, 0, 0, 1));
        step(1, 0, 0, 0, 0, 0, "to_c10", IDLE1);

        // end flag in the final allowed cycle wins
        step(1, 1, 0, 0, 0, 0, "tl_c0", IDLE1);
        step(1, 0, 0, 0, 0, 0, "tl_c1", ev(1, 0, 1, 0, 1, 0, 0, 0));
        for (int c = 2; c <= 7; c++)
            step(1, 0, 0, 0, 0, 0, "tl_run", ev(0, 0, 1, 0, 1, 0, 0, 0));
        step(1, 0, 0, 1, 0, 0, "tl_c8", ev(0, 0, 1, 0, 1, 0, 0, 0));
        step(1, 0, 0, 0, 0, 0, "tl_c9", ev(0, 0, 0, 1, 1, 1, 0, 0));
        step(1, 0, 0, 0, 0, 0, "tl_c10", IDLE0);
`else
        // no watchdog: RUN waits indefinitely
        step(1, 1, 0, 0, 0, 0, "nt_c0", IDLE1);
        step(1, 0, 0, 0, 0, 0, "nt_c1", ev(1, 0, 1, 0, 1, 0, 0, 0));
        for (int c = 2; c <= 40; c++)
            step(1, 0, 0, 0, 0, 0, "nt_run", ev(0, 0, 1, 0, 1, 0, 0, 0));
        step(1, 0, 0, 1, 0, 0, "nt_end", ev(0, 0, 1, 0, 1, 0, 0, 0));
        step(1, 0, 0, 0, 0, 0, "nt_wr", ev(0, 0, 0, 1, 1, 1, 0, 0));
        step(1, 0, 0, 0, 0, 0, "nt_idle", IDLE0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
